// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial add/subtract unit. Operands arrive LSB-first, one bit per
//   accepted cycle, framed by a start marker. The result leaves LSB-first one
//   cycle later. Four operations are supported: a+b, a-b, a+1 and 0-a.
//   Completed words also report a carry-out flag and a signed-overflow flag.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   in_valid   a/b (and in_start/mode) carry a bit this cycle
//   in_start   with in_valid: this bit is the LSB of a new word
//   mode       latched on an accepted start bit:
//              00 add, 01 sub, 10 inc, 11 neg
//   a, b       operand serial bits (b is ignored by inc/neg)
//   out        result serial bit (registered; qualify with out_valid)
//   out_valid  out carries a result bit
//   out_last   out is bit WIDTH-1 of the word
//   carry_out  final carry of the last completed word (sub: 1 = no borrow)
//   overflow   signed overflow of the last completed word
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       out,
  output logic       out_valid,
  output logic       out_last,
  output logic       carry_out,
  output logic       overflow
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_INC = 2'b10,
    MODE_NEG = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Registered state
  state_e          r_state;
  mode_e           r_mode;
  logic [CW-1:0]   r_cnt;
  logic            r_carry;
  logic            r_out;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_carry_out;
  logic            r_overflow;

  // Per-bit datapath
  logic            w_start;
  logic            w_accept;
  mode_e           w_mode;
  logic            w_c_in;
  logic [CW-1:0]   w_idx;
  logic            w_last;
  logic            w_x;
  logic            w_y;
  logic            w_sum;
  logic            w_c_next;

  // A start bit always begins a fresh word, whether we are idle or mid-word
  // (abort). Mode and the initial carry therefore come straight from the
  // inputs on a start bit so that bit 0 is processed in the same cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    w_x      = 1'b0;
    w_y      = 1'b0;
    w_start  = in_valid & in_start;
    w_accept = in_valid & (in_start | (r_state == RUN));
    w_mode   = w_start ? mode_e'(mode) : r_mode;
    // Subtract, increment and negate all need a +1 injected at the LSB.
    w_c_in   = w_start ? (mode_e'(mode) != MODE_ADD) : r_carry;
    w_idx    = w_start ? '0 : r_cnt;
    w_last   = (w_idx == LAST_IDX);

    case (w_mode)
      MODE_ADD: begin w_x = a;    w_y = b;  end
      MODE_SUB: begin w_x = a;    w_y = ~b; end
      MODE_INC: begin w_x = a;    w_y = 1'b0; end
      MODE_NEG: begin w_x = 1'b0; w_y = ~a; end
      default:  begin w_x = a;    w_y = b;  end
    endcase

    w_sum    = w_x ^ w_y ^ w_c_in;
    w_c_next = (w_x & w_y) | (w_x & w_c_in) | (w_y & w_c_in);
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_mode      <= MODE_ADD;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;

      if (w_accept) begin
        r_out       <= w_sum;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last;
        r_mode      <= w_mode;
        r_carry     <= w_c_next;

        if (w_last) begin
          r_carry_out <= w_c_next;
          // Carry into the MSB differs from carry out of it on signed overflow.
          r_overflow  <= w_c_in ^ w_c_next;
          r_state     <= IDLE;
          r_cnt       <= '0;
        end else begin
          r_state     <= RUN;
          r_cnt       <= w_idx + CW'(1);
        end
      end
      // A stall (in_valid low in RUN) falls through: count, carry and mode hold.
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH = 4). Directed vectors come
//   from a table; multi-cycle corners (stall, back-to-back, abort, reset) are
//   hand-written; random words are checked against an integer reference model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int W = 4;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] INC = 2'b10;
  localparam logic [1:0] NEG = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_start;
  logic [1:0] mode;
  logic       a;
  logic       b;
  logic       out;
  logic       out_valid;
  logic       out_last;
  logic       carry_out;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_start  (in_start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Output monitor: reassembles words from the serial stream. The last W valid
  // bits form the word when out_last is seen, so abandoned partial words drop
  // out naturally.
  // ---------------------------------------------------------------------------
  typedef struct {
    int res;
    bit c;
    bit v;
    int gap;
  } obs_t;

  obs_t          obs_q[$];
  obs_t          last_obs;
  logic [W-1:0]  win = '0;
  int            cyc = 0;
  int            last_v = 0;
  int            bits_in_word = 0;
  int            gap_acc = 0;
  int            run = 0;
  int            max_run = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      bits_in_word = 0;
      gap_acc      = 0;
      run          = 0;
    end else if (out_valid) begin
      win = {out, win[W-1:1]};
      run++;
      if (run > max_run) max_run = run;
      if (bits_in_word > 0) gap_acc += cyc - last_v - 1;
      last_v = cyc;
      bits_in_word++;
      if (out_last) begin
        obs_q.push_back('{res: int'(win), c: carry_out, v: overflow, gap: gap_acc});
        bits_in_word = 0;
        gap_acc      = 0;
      end
    end else begin
      run = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain integer arithmetic on whole words.
  // ---------------------------------------------------------------------------
  function automatic int to_signed(input int u);
    return (u >= 2**(W-1)) ? u - 2**W : u;
  endfunction

  function automatic void model(input logic [1:0] m, input int ua, input int ub,
                                output int res, output bit c, output bit v);
    int full;
    int sres;
    int sa;
    int sb;
    sa = to_signed(ua);
    sb = to_signed(ub);
    case (m)
      ADD:     begin full = ua + ub;                 sres = sa + sb; end
      SUB:     begin full = ua + (2**W - 1 - ub) + 1; sres = sa - sb; end
      INC:     begin full = ua + 1;                  sres = sa + 1;  end
      default: begin full = (2**W - 1 - ua) + 1;     sres = -sa;     end
    endcase
    res = full % (2**W);
    c   = (full >= 2**W);
    v   = (sres < -(2**(W-1))) || (sres > 2**(W-1) - 1);
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_word(input string name, input int er, input bit ec, input bit ev);
    check({name, " word present"}, 32'(obs_q.size() != 0), 1);
    if (obs_q.size() != 0) begin
      last_obs = obs_q.pop_front();
      check({name, " result"},    last_obs.res, er);
      check({name, " carry_out"}, last_obs.c,   ec);
      check({name, " overflow"},  last_obs.v,   ev);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_start = 1'b0;
      mode     = 2'($urandom);
      a        = 1'($urandom);
      b        = 1'($urandom);
    end
  endtask

  // Sends nbits bits of a word. Before bit index stall_before, stall_len
  // cycles with in_valid low are inserted. Mode is scrambled on non-start
  // bits since it must only be sampled with the start bit.
  task automatic send_word(input logic [1:0] m, input int ua, input int ub,
                           input int nbits, input int stall_before, input int stall_len);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_before) idle(stall_len);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_start = (i == 0);
      mode     = (i == 0) ? m : 2'($urandom);
      a        = 1'((ua >> i) & 1);
      b        = 1'((ub >> i) & 1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (expected values worked out by hand)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] m;
    int         a;
    int         b;
    int         res;
    bit         c;
    bit         v;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   er;
    bit   ec;
    bit   ev;
    vec_t rexp[$];

    vecs[0] = '{ADD,  5,  3,  8, 1'b0, 1'b1};
    vecs[1] = '{SUB,  3,  5, 14, 1'b0, 1'b0};
    vecs[2] = '{NEG,  8,  0,  8, 1'b0, 1'b1};
    vecs[3] = '{NEG,  0,  9,  0, 1'b1, 1'b0};
    vecs[4] = '{SUB,  7,  2,  5, 1'b1, 1'b0};
    vecs[5] = '{ADD,  7,  1,  8, 1'b0, 1'b1};
    vecs[6] = '{SUB,  8,  1,  7, 1'b1, 1'b1};
    vecs[7] = '{INC, 15,  6,  0, 1'b1, 1'b0};
    vecs[8] = '{ADD, 15, 15, 14, 1'b1, 1'b0};

    reset    = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    mode     = 2'b00;
    a        = 1'b0;
    b        = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out",       out,       0);
    check("reset out_valid", out_valid, 0);
    check("reset out_last",  out_last,  0);
    check("reset carry_out", carry_out, 0);
    check("reset overflow",  overflow,  0);
    reset = 1'b1;

    // Table-driven directed words
    for (int i = 0; i < 9; i++) begin
      obs_q.delete();
      send_word(vecs[i].m, vecs[i].a, vecs[i].b, W, -1, 0);
      idle(2);
      expect_word($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v);
      check($sformatf("vec%0d extra words", i), obs_q.size(), 0);
    end

    // Stall: ADD 5+3 with two dead cycles between bit 1 and bit 2
    obs_q.delete();
    send_word(ADD, 5, 3, W, 2, 2);
    idle(2);
    expect_word("stall", 8, 1'b0, 1'b1);
    check("stall out_valid gap", last_obs.gap, 2);

    // INC 0..15 back-to-back, no bubbles
    obs_q.delete();
    max_run = 0;
    for (int v = 0; v < 16; v++) send_word(INC, v, int'($urandom_range(0, 15)), W, -1, 0);
    idle(3);
    check("inc word count", obs_q.size(), 16);
    for (int v = 0; v < 16; v++) begin
      model(INC, v, 0, er, ec, ev);
      expect_word($sformatf("inc%0d", v), er, ec, ev);
    end
    check("inc contiguous out_valid", max_run, 64);

    // Abort: two bits of an ADD, then a full SUB 7-2 started immediately
    obs_q.delete();
    send_word(ADD, 15, 15, 2, -1, 0);
    send_word(SUB, 7, 2, W, -1, 0);
    idle(2);
    check("abort word count", obs_q.size(), 1);
    expect_word("abort sub", 5, 1'b1, 1'b0);

    // Abort must not disturb flags: complete a word with c=0,v=1, abort a word
    obs_q.delete();
    send_word(ADD, 5, 3, W, -1, 0);
    send_word(SUB, 7, 2, 3, -1, 0);
    idle(3);
    check("abort holds carry_out", carry_out, 0);
    check("abort holds overflow",  overflow,  1);
    check("abort no out_last", obs_q.size(), 1);

    // Reset mid-word: set flags to 1/1, emit a 1 bit, then reset
    obs_q.delete();
    send_word(SUB, 8, 1, W, -1, 0);
    idle(2);
    expect_word("pre-reset", 7, 1'b1, 1'b1);
    send_word(ADD, 1, 0, 1, -1, 0);
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset out bit", out, 1);
    @(posedge clk);
    @(negedge clk);
    check("midreset out",       out,       0);
    check("midreset out_valid", out_valid, 0);
    check("midreset out_last",  out_last,  0);
    check("midreset carry_out", carry_out, 0);
    check("midreset overflow",  overflow,  0);
    reset = 1'b1;
    obs_q.delete();
    send_word(ADD, 5, 3, W, -1, 0);
    idle(2);
    expect_word("post-reset", 8, 1'b0, 1'b1);

    // Random words with random stalls and gaps, against the model
    obs_q.delete();
    for (int k = 0; k < 60; k++) begin
      logic [1:0] rm;
      int         ra;
      int         rb;
      int         sb;
      rm = 2'($urandom_range(0, 3));
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1;
      send_word(rm, ra, rb, W, sb, int'($urandom_range(1, 3)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      model(rm, ra, rb, er, ec, ev);
      rexp.push_back('{rm, ra, rb, er, ec, ev});
    end
    idle(3);
    check("random word count", obs_q.size(), rexp.size());
    foreach (rexp[k]) begin
      expect_word($sformatf("rand%0d m%0d a%0d b%0d", k, rexp[k].m, rexp[k].a, rexp[k].b),
                  rexp[k].res, rexp[k].c, rexp[k].v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
